// File: rtl/gray_convert.sv
// RGB-to-luminance stage: reads the shrunk frame one pixel per clock, writes 8-bit gray at the same address, pulses done.
// Optional GRAY_ROUND_EN adds +128 before the >>8 for round-to-nearest; default build truncates.
module gray_convert #(
  parameter int BPP    = 3,
  parameter int WIDTH  = 15,
  parameter int HEIGHT = 15,
  localparam int PIXELS = WIDTH * HEIGHT,
  localparam int AW     = $clog2(PIXELS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [8*BPP-1:0]   pixel_in,
  output logic [AW-1:0]      read_addr,
  output logic [7:0]         pixel_out,
  output logic [AW-1:0]      write_addr,
  output logic               wr_en,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(PIXELS - 1);

  state_t          state_q;
  logic [AW-1:0]   read_addr_q;
  logic [AW-1:0]   addr1_q;
  logic [AW-1:0]   write_addr_q;
  logic [7:0]      pixel_out_q;
  logic            vld1_q;
  logic            wr_en_q;
  logic            done_q;
  logic            arm_q;
  logic            flush_q;
  logic [7:0]      gray_d;

  generate
    if (BPP == 3) begin : g_rgb
`ifdef GRAY_ROUND_EN
      localparam logic [15:0] RND = 16'd128;
`else
      localparam logic [15:0] RND = 16'd0;
`endif
      // Weights sum to 256, so the 16-bit sum peaks at 65408 and never overflows.
      logic [15:0] acc;
      always_comb begin
        acc = 16'd77  * {8'd0, pixel_in[23:16]}
            + 16'd150 * {8'd0, pixel_in[15:8]}
            + 16'd29  * {8'd0, pixel_in[7:0]}
            + RND;
      end
      assign gray_d = acc[15:8];
    end else if (BPP == 1) begin : g_pass
      assign gray_d = pixel_in;
    end else begin : g_bad
      $error("gray_convert: BPP must be 1 or 3");
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      read_addr_q  <= '0;
      addr1_q      <= '0;
      write_addr_q <= '0;
      pixel_out_q  <= 8'd0;
      vld1_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      done_q       <= 1'b0;
      arm_q        <= 1'b1;
      flush_q      <= 1'b0;
    end else begin
      // Stage 1 tracks the read in flight while the memory fetches it.
      vld1_q  <= (state_q == RUN);
      addr1_q <= read_addr_q;
      wr_en_q <= vld1_q;
      if (vld1_q) begin
        write_addr_q <= addr1_q;
        pixel_out_q  <= gray_d;
      end
      done_q <= 1'b0;

      if (!start && state_q != RUN && state_q != FLUSH)
        arm_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start && arm_q) begin
            state_q     <= RUN;
            arm_q       <= 1'b0;
            read_addr_q <= '0;
          end
        end
        RUN: begin
          if (read_addr_q == LAST) begin
            state_q <= FLUSH;
            flush_q <= 1'b0;
          end else begin
            read_addr_q <= read_addr_q + AW'(1);
          end
        end
        FLUSH: begin
          if (flush_q) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            read_addr_q <= '0;
          end else begin
            flush_q <= 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read_addr  = read_addr_q;
  assign write_addr = write_addr_q;
  assign pixel_out  = pixel_out_q;
  assign wr_en      = wr_en_q;
  assign done       = done_q;

endmodule

// File: tb/tb_gray_convert.sv
// Directed bench for gray_convert: RGB 15x15 instance plus a 4x4 pass-through instance.
module tb_gray_convert;

  localparam int PIX = 225;
  localparam int P1  = 16;

`ifdef GRAY_ROUND_EN
  localparam logic [7:0] R_EXP = 8'h4D;
  localparam logic [7:0] B_EXP = 8'h1D;
`else
  localparam logic [7:0] R_EXP = 8'h4C;
  localparam logic [7:0] B_EXP = 8'h1C;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start1;
  logic [23:0] pixel_in;
  logic [7:0]  read_addr, write_addr, pixel_out;
  logic        wr_en, done;
  logic [7:0]  pixel_in1, pixel_out1;
  logic [3:0]  read_addr1, write_addr1;
  logic        wr_en1, done1;

  logic [23:0] mem    [0:PIX-1];
  logic [7:0]  mem1   [0:P1-1];
  logic [7:0]  exp_px [0:PIX-1];
  logic [7:0]  got    [0:PIX-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_convert dut (
    .clk(clk), .rst(rst), .start(start), .pixel_in(pixel_in),
    .read_addr(read_addr), .pixel_out(pixel_out), .write_addr(write_addr),
    .wr_en(wr_en), .done(done)
  );

  gray_convert #(.BPP(1), .WIDTH(4), .HEIGHT(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pixel_in(pixel_in1),
    .read_addr(read_addr1), .pixel_out(pixel_out1), .write_addr(write_addr1),
    .wr_en(wr_en1), .done(done1)
  );

  // Synchronous-read source memories.
  always @(posedge clk) begin
    pixel_in  <= mem[read_addr];
    pixel_in1 <= mem1[read_addr1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Raises start, then observes one full frame cycle by cycle (cycle 0 = first RUN cycle).
  task automatic frame(input string tag, input int drop_at);
    int nwr = 0, badaddr = 0, baddata = 0, badrd = 0, ndone = 0, dcyc = -1, firstwr = -1;
    int erd;
    start = 1'b1;
    for (int c = 0; c < PIX + 8; c++) begin
      @(negedge clk);
      if (c == drop_at) start = 1'b0;
      erd = (c < PIX) ? c : (c <= PIX + 1) ? PIX - 1 : 0;
      if (read_addr !== 8'(erd)) badrd++;
      if (wr_en === 1'b1) begin
        if (firstwr < 0) firstwr = c;
        if (nwr < PIX) begin
          if (write_addr !== 8'(nwr)) badaddr++;
          if (pixel_out !== exp_px[nwr]) baddata++;
          got[nwr] = pixel_out;
        end
        nwr++;
      end
      if (done === 1'b1) begin
        ndone++;
        dcyc = c;
      end
    end
    check({tag, ".nwr"}, nwr, PIX);
    check({tag, ".first_wr_cycle"}, firstwr, 2);
    check({tag, ".bad_addr"}, badaddr, 0);
    check({tag, ".bad_data"}, baddata, 0);
    check({tag, ".bad_read_addr"}, badrd, 0);
    check({tag, ".done_count"}, ndone, 1);
    check({tag, ".done_cycle"}, dcyc, PIX + 2);
  endtask

  initial begin
    int found, extra, n1, bad1, d1cyc, f1;
    rst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    for (int i = 0; i < PIX; i++) begin
      mem[i] = 24'hFF0000;
      exp_px[i] = R_EXP;
    end
    for (int i = 0; i < P1; i++) mem1[i] = 8'(i * 3);
    repeat (3) @(negedge clk);

    check("rst.wr_en", wr_en, 0);
    check("rst.done", done, 0);
    check("rst.read_addr", read_addr, 0);
    check("rst.write_addr", write_addr, 0);
    check("rst.pixel_out", pixel_out, 0);
    check("rst.wr_en1", wr_en1, 0);
    rst = 1'b0;
    @(negedge clk);

    // All-red frame.
    frame("red", 0);
    check("red.px0", got[0], R_EXP);
    check("red.px224", got[224], R_EXP);

    // Corner colours at the first four addresses.
    mem[0] = 24'h00FF00; exp_px[0] = 8'h95;
    mem[1] = 24'h0000FF; exp_px[1] = B_EXP;
    mem[2] = 24'hFFFFFF; exp_px[2] = 8'hFF;
    mem[3] = 24'h000000; exp_px[3] = 8'h00;
    @(negedge clk);
    frame("pat", 0);
    check("pat.green", got[0], 8'h95);
    check("pat.blue", got[1], B_EXP);
    check("pat.white", got[2], 8'hFF);
    check("pat.black", got[3], 8'h00);

    // Start held high: no retrigger until start drops.
    frame("hold", -1);
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (wr_en === 1'b1 || done === 1'b1) extra++;
    end
    check("hold.no_retrigger", extra, 0);
    start = 1'b0;
    @(negedge clk);
    frame("rearm", 0);

    // Reset mid-frame when writing address 100.
    start = 1'b1;
    found = 0;
    for (int c = 0; c < 300 && found == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (wr_en === 1'b1 && write_addr === 8'd100) found = 1;
    end
    check("midrst.reached_100", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst.wr_en", wr_en, 0);
    check("midrst.read_addr", read_addr, 0);
    check("midrst.write_addr", write_addr, 0);
    check("midrst.pixel_out", pixel_out, 0);
    rst = 1'b0;
    extra = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (wr_en === 1'b1 || done === 1'b1) extra++;
    end
    check("midrst.quiet", extra, 0);
    frame("restart", 0);

    // Start dropped mid-frame.
    frame("drop50", 50);

    // Pass-through 4x4 instance.
    n1 = 0; bad1 = 0; d1cyc = -1; f1 = -1;
    start1 = 1'b1;
    for (int c = 0; c < P1 + 8; c++) begin
      @(negedge clk);
      if (c == 0) start1 = 1'b0;
      if (wr_en1 === 1'b1) begin
        if (f1 < 0) f1 = c;
        if (write_addr1 !== 4'(n1) || pixel_out1 !== 8'(n1 * 3)) bad1++;
        n1++;
      end
      if (done1 === 1'b1) d1cyc = c;
    end
    check("bpp1.nwr", n1, P1);
    check("bpp1.first_wr_cycle", f1, 2);
    check("bpp1.bad_writes", bad1, 0);
    check("bpp1.done_cycle", d1cyc, 18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
